// File: rtl/zone_alarm.sv
// Multi-zone intrusion alarm: IDLE/ARMED/ENTRY/ALARM controller with panic, entry delay and zone latch.
// Latency: a trigger sampled on a rising edge shows on L/st right after that same edge; all outputs come from registers.
// Backpressure: none; inputs are sampled on every rising edge, and clr only acts in ALARM while X=1 and A=0.
module zone_alarm #(
   parameter int N     = 4,
   parameter int DELAY = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] D,
   input  logic         X,
   input  logic         A,
   input  logic         clr,
   output logic         L,
   output logic [N-1:0] zone,
   output logic         P,
   output logic         pend,
   output logic [7:0]   cnt,
   output logic [1:0]   st
);

   // The entry-delay counter is 8 bits wide, so larger delays cannot be represented.
   generate
      if (DELAY < 0 || DELAY > 255) begin : g_bad_delay
         $error("zone_alarm: DELAY must be within 0..255");
      end
      if (N < 1 || N > 32) begin : g_bad_n
         $error("zone_alarm: N must be within 1..32");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_ENTRY = 2'd2,
      S_ALARM = 2'd3
   } state_t;

   localparam logic [7:0] C_DELAY = 8'(DELAY);

   state_t         r_st;
   state_t         w_st_nxt;
   logic [7:0]     r_cnt;
   logic [7:0]     w_cnt_nxt;
   logic [N-1:0]   r_zone;
   logic [N-1:0]   w_zone_nxt;
   logic           r_p;
   logic           w_p_nxt;

   // Next state, entry countdown, zone latch and panic flag; panic overrides everything else.
   always_comb begin
      w_st_nxt   = r_st;
      w_cnt_nxt  = 8'd0;
      w_zone_nxt = r_zone;
      w_p_nxt    = r_p | A;

      if (A) begin
         w_st_nxt = S_ALARM;
      end else begin
         case (r_st)
            S_IDLE: begin
               if (!X) w_st_nxt = S_ARMED;
            end
            S_ARMED: begin
               if (X) begin
                  w_st_nxt = S_IDLE;
               end else if (|D) begin
                  if (DELAY == 0) begin
                     w_st_nxt = S_ALARM;
                  end else begin
                     w_st_nxt  = S_ENTRY;
                     w_cnt_nxt = C_DELAY;
                  end
               end
            end
            S_ENTRY: begin
               // Last remaining cycle (or a zero count) expires into ALARM, so the counter never wraps.
               if (X) begin
                  w_st_nxt = S_IDLE;
               end else if (r_cnt <= 8'd1) begin
                  w_st_nxt = S_ALARM;
               end else begin
                  w_cnt_nxt = r_cnt - 8'd1;
               end
            end
            S_ALARM: begin
               if (clr && X) w_st_nxt = S_IDLE;
            end
            default: w_st_nxt = S_IDLE;
         endcase
      end

      // Zones accumulate only while the system is armed in some form and the key is not disarming.
      if (r_st != S_IDLE && !X) w_zone_nxt = r_zone | D;

      // Returning to IDLE wipes the event history.
      if (w_st_nxt == S_IDLE) begin
         w_zone_nxt = '0;
         w_p_nxt    = 1'b0;
      end
   end

   // State and history registers; reset aborts any delay or alarm immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_st   <= S_IDLE;
         r_cnt  <= 8'd0;
         r_zone <= '0;
         r_p    <= 1'b0;
      end else begin
         r_st   <= w_st_nxt;
         r_cnt  <= w_cnt_nxt;
         r_zone <= w_zone_nxt;
         r_p    <= w_p_nxt;
      end
   end

   assign L    = (r_st == S_ALARM);
   assign pend = (r_st == S_ENTRY);
   assign cnt  = r_cnt;
   assign zone = r_zone;
   assign P    = r_p;
   assign st   = r_st;

endmodule

// File: tb/tb_zone_alarm.sv
// Bench for zone_alarm: two instances (DELAY=3 and DELAY=0) share stimulus.
// Directed scenarios plus randomized cycles checked against a behavioural model.
// Outputs are sampled 1 time unit after each rising edge.
module tb_zone_alarm;

   logic       clk;
   logic       rst_n;
   logic [3:0] D;
   logic       X;
   logic       A;
   logic       clr;

   logic       l3, p3, pend3;
   logic [3:0] zone3;
   logic [7:0] cnt3;
   logic [1:0] st3;
   logic       l0, p0, pend0;
   logic [3:0] zone0;
   logic [7:0] cnt0;
   logic [1:0] st0;

   int n_chk  = 0;
   int n_fail = 0;

   // behavioural model, index 0 -> DELAY=3 instance, index 1 -> DELAY=0 instance
   int         m_mode [2];   // 0 idle, 1 armed, 2 entry, 3 alarm
   int         m_el   [2];   // cycles already spent in entry
   logic [3:0] m_zone [2];
   logic       m_p    [2];
   int         dly    [2];

   zone_alarm #(.N(4), .DELAY(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .D(D), .X(X), .A(A), .clr(clr),
      .L(l3), .zone(zone3), .P(p3), .pend(pend3), .cnt(cnt3), .st(st3)
   );

   zone_alarm #(.N(4), .DELAY(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .D(D), .X(X), .A(A), .clr(clr),
      .L(l0), .zone(zone0), .P(p0), .pend(pend0), .cnt(cnt0), .st(st0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_mode[k] = 0;
         m_el[k]   = 0;
         m_zone[k] = 4'd0;
         m_p[k]    = 1'b0;
      end
   endtask

   task automatic model_step();
      int old;
      for (int k = 0; k < 2; k++) begin
         old = m_mode[k];
         if (old != 0 && !X) m_zone[k] = m_zone[k] | D;
         if (A) begin
            m_mode[k] = 3;
            m_p[k]    = 1'b1;
         end else begin
            case (old)
               0: if (!X) m_mode[k] = 1;
               1: begin
                  if (X) m_mode[k] = 0;
                  else if (D != 4'd0) begin
                     if (dly[k] == 0) m_mode[k] = 3;
                     else begin
                        m_mode[k] = 2;
                        m_el[k]   = 0;
                     end
                  end
               end
               2: begin
                  if (X) m_mode[k] = 0;
                  else begin
                     m_el[k] = m_el[k] + 1;
                     if (m_el[k] >= dly[k]) m_mode[k] = 3;
                  end
               end
               default: if (clr && X) m_mode[k] = 0;
            endcase
         end
         if (m_mode[k] == 0) begin
            m_zone[k] = 4'd0;
            m_p[k]    = 1'b0;
         end
      end
   endtask

   function automatic logic [16:0] model_vec(int k);
      logic [7:0] c;
      c = (m_mode[k] == 2) ? 8'(dly[k] - m_el[k]) : 8'd0;
      return {2'(m_mode[k]), m_mode[k] == 3, m_p[k], m_mode[k] == 2, c, m_zone[k]};
   endfunction

   // one rising edge, model advanced with the inputs present at that edge
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      X = 1'b1; A = 1'b0; clr = 1'b0; D = 4'd0;
      #1;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      model_step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; X = 1'b1; A = 1'b0; clr = 1'b0; D = 4'd0;
      #3;
      n_chk++;
      if ({st3, l3, p3, pend3, cnt3, zone3} !== 17'd0) begin
         n_fail++;
         $display("FAIL reset_state got=%h exp=%h", {st3, l3, p3, pend3, cnt3, zone3}, 17'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      model_step();
   endtask

   task automatic test_entry_alarm();
      logic [7:0] exp_c;
      do_reset();
      X = 1'b0;
      tick();
      n_chk++;
      if (st3 !== 2'd1) begin n_fail++; $display("FAIL entry_armed st got=%0d exp=1", st3); end
      D = 4'b0010;
      tick();
      D = 4'd0;
      for (int i = 0; i < 3; i++) begin
         exp_c = 8'(3 - i);
         n_chk++;
         if ({st3, pend3, l3, cnt3} !== {2'd2, 1'b1, 1'b0, exp_c}) begin
            n_fail++;
            $display("FAIL entry_count step=%0d got st=%0d pend=%b L=%b cnt=%0d exp cnt=%0d", i, st3, pend3, l3, cnt3, exp_c);
         end
         tick();
      end
      n_chk++;
      if ({st3, l3, pend3, cnt3, zone3} !== {2'd3, 1'b1, 1'b0, 8'd0, 4'b0010}) begin
         n_fail++;
         $display("FAIL entry_alarm got st=%0d L=%b pend=%b cnt=%0d zone=%b exp st=3 L=1 pend=0 cnt=0 zone=0010", st3, l3, pend3, cnt3, zone3);
      end
   endtask

   task automatic test_disarm();
      logic seen_l;
      do_reset();
      seen_l = 1'b0;
      X = 1'b0;
      tick();
      D = 4'b0010;
      tick();
      seen_l = seen_l | l3;
      D = 4'd0;
      tick();
      seen_l = seen_l | l3;
      n_chk++;
      if (cnt3 !== 8'd2) begin n_fail++; $display("FAIL disarm_cnt got=%0d exp=2", cnt3); end
      X = 1'b1;
      tick();
      seen_l = seen_l | l3;
      n_chk++;
      if ({st3, zone3, seen_l, cnt3} !== {2'd0, 4'd0, 1'b0, 8'd0}) begin
         n_fail++;
         $display("FAIL disarm_idle got st=%0d zone=%b Lseen=%b cnt=%0d exp st=0 zone=0000 Lseen=0 cnt=0", st3, zone3, seen_l, cnt3);
      end
   endtask

   task automatic test_panic();
      do_reset();
      X = 1'b1; A = 1'b1;
      tick();
      A = 1'b0;
      n_chk++;
      if ({st3, l3, p3, zone3} !== {2'd3, 1'b1, 1'b1, 4'd0}) begin
         n_fail++;
         $display("FAIL panic_alarm got st=%0d L=%b P=%b zone=%b exp st=3 L=1 P=1 zone=0000", st3, l3, p3, zone3);
      end
      A = 1'b1; clr = 1'b1;
      tick();
      n_chk++;
      if ({st3, p3} !== {2'd3, 1'b1}) begin
         n_fail++;
         $display("FAIL panic_with_clr got st=%0d P=%b exp st=3 P=1", st3, p3);
      end
      A = 1'b0;
      tick();
      clr = 1'b0;
      n_chk++;
      if ({st3, l3, p3} !== {2'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL panic_clear got st=%0d L=%b P=%b exp st=0 L=0 P=0", st3, l3, p3);
      end
   endtask

   task automatic test_clr_armed();
      do_reset();
      X = 1'b0; A = 1'b1;
      tick();
      A = 1'b0; clr = 1'b1;
      tick();
      n_chk++;
      if (st3 !== 2'd3) begin n_fail++; $display("FAIL clr_keyed_armed got st=%0d exp=3", st3); end
      X = 1'b1;
      tick();
      clr = 1'b0;
      n_chk++;
      if (st3 !== 2'd0) begin n_fail++; $display("FAIL clr_disarmed got st=%0d exp=0", st3); end
   endtask

   task automatic test_delay0();
      logic seen_pend;
      do_reset();
      seen_pend = 1'b0;
      X = 1'b0;
      tick();
      seen_pend = seen_pend | pend0;
      D = 4'b1000;
      tick();
      seen_pend = seen_pend | pend0;
      D = 4'd0;
      n_chk++;
      if ({st0, l0, seen_pend, zone0} !== {2'd3, 1'b1, 1'b0, 4'b1000}) begin
         n_fail++;
         $display("FAIL delay0_alarm got st=%0d L=%b pendseen=%b zone=%b exp st=3 L=1 pendseen=0 zone=1000", st0, l0, seen_pend, zone0);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      X = 1'b0;
      tick();
      D = 4'b0100;
      tick();
      D = 4'd0;
      n_chk++;
      if (pend3 !== 1'b1) begin n_fail++; $display("FAIL areset_pre pend got=%b exp=1", pend3); end
      #2;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({st3, l3, pend3, cnt3, zone3, p3} !== 17'd0) begin
         n_fail++;
         $display("FAIL areset_async got st=%0d L=%b pend=%b cnt=%0d zone=%b P=%b exp all 0", st3, l3, pend3, cnt3, zone3, p3);
      end
      rst_n = 1'b1;
      model_reset();
      tick();
      n_chk++;
      if (st3 !== 2'd1) begin n_fail++; $display("FAIL areset_restart got st=%0d exp=1", st3); end
   endtask

   task automatic test_random();
      logic [16:0] e3, e0;
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         A   = ($urandom_range(0, 39) == 0);
         X   = ($urandom_range(0, 9) < 2);
         clr = ($urandom_range(0, 3) == 0);
         D   = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'd0;
         tick();
         e3 = model_vec(0);
         e0 = model_vec(1);
         n_chk++;
         if ({st3, l3, p3, pend3, cnt3, zone3} !== e3) begin
            n_fail++;
            $display("FAIL random_d3 cyc=%0d got=%h exp=%h", i, {st3, l3, p3, pend3, cnt3, zone3}, e3);
         end
         n_chk++;
         if ({st0, l0, p0, pend0, cnt0, zone0} !== e0) begin
            n_fail++;
            $display("FAIL random_d0 cyc=%0d got=%h exp=%h", i, {st0, l0, p0, pend0, cnt0, zone0}, e0);
         end
      end
   endtask

   initial begin
      dly[0] = 3;
      dly[1] = 0;
      model_reset();
      test_reset();
      test_entry_alarm();
      test_disarm();
      test_panic();
      test_clr_armed();
      test_delay0();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/zone_alarm.md
ZONE_ALARM -- requirements
Module: zone_alarm

Interface
REQ-001 Parameter N, default 4, number of sensor zones (1..32).
REQ-002 Parameter DELAY, default 8, entry-delay length in clock cycles (0..255).
REQ-003 Port clk  input  1  single clock, rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port D  input  N  per-zone sensor open (1 = open).
REQ-006 Port X  input  1  key switch (1 = disarmed, 0 = armed request).
REQ-007 Port A  input  1  panic (1 = immediate alarm).
REQ-008 Port clr  input  1  alarm acknowledge/clear request.
REQ-009 Port L  output  1  alarm active, registered.
REQ-010 Port zone  output  N  latched zones that tripped since last IDLE.
REQ-011 Port P  output  1  latched panic-cause flag.
REQ-012 Port pend  output  1  entry delay running.
REQ-013 Port cnt  output  8  entry-delay cycles remaining (0 outside ENTRY).
REQ-014 Port st  output  2  state code: IDLE=0, ARMED=1, ENTRY=2, ALARM=3.

Function
REQ-015 States IDLE, ARMED, ENTRY and ALARM SHALL be held in registered state st; all outputs SHALL be registered or decoded from registers only.
REQ-016 Panic SHALL have priority: A=1 at any edge in any state SHALL move to ALARM on that edge and set P=1, regardless of X, D or clr.
REQ-017 IDLE: X=0 SHALL move to ARMED; otherwise stay; D SHALL be ignored.
REQ-018 ARMED: X=1 SHALL move to IDLE (disarm wins over simultaneous D); else any D bit set SHALL move to ENTRY with cnt loaded to DELAY.
REQ-019 ARMED with DELAY=0: any D bit set with X=0 SHALL move directly to ALARM.
REQ-020 ENTRY: cnt SHALL decrement by 1 per cycle; X=1 SHALL move to IDLE (disarm in time); when cnt==1 and X=0 the next edge SHALL move to ALARM; cnt SHALL never wrap below 0.
REQ-021 ENTRY SHALL last exactly DELAY cycles before ALARM when X stays 0; further D activity SHALL NOT reload cnt.
REQ-022 ALARM: SHALL stay until clr=1 with X=1 and A=0, then move to IDLE; clr with X=0 SHALL be ignored.
REQ-023 zone SHALL OR in D on every edge where st is ARMED, ENTRY or ALARM and X=0; zone SHALL be cleared on entry to IDLE.
REQ-024 P SHALL be cleared only on entry to IDLE.
REQ-025 L SHALL equal (st==ALARM); pend SHALL equal (st==ENTRY); latency from triggering edge to L=1 SHALL be zero additional cycles beyond the state transition edge.
REQ-026 Width rule: cnt SHALL be 8 bits; DELAY values above 255 SHALL be illegal and flagged by an elaboration-time check.
REQ-027 Simultaneous A=1 and clr=1 in ALARM SHALL keep ALARM.

Reset
REQ-028 rst_n=0 SHALL asynchronously force st=IDLE, L=0, zone=0, P=0, pend=0, cnt=0, regardless of clk.
REQ-029 Reset asserted mid-ENTRY or mid-ALARM SHALL abort immediately; after release the block SHALL evaluate from IDLE on the first rising edge.

Verification
REQ-030 N=4, DELAY=3: X=0, then D=4'b0010 for one cycle, X held 0 -> ENTRY with cnt 3,2,1, ALARM on 4th edge after D, L=1, zone=4'b0010.
REQ-031 Same setup, X=1 while cnt=2 -> IDLE next edge, L never 1, zone=0.
REQ-032 IDLE, A=1 pulse one cycle with X=1 -> ALARM, L=1, P=1, zone=0; clr=1 with X=1 -> IDLE, P=0.
REQ-033 ALARM, clr=1 with X=0 -> stays ALARM; then X=1 with clr=1 -> IDLE next edge.
REQ-034 DELAY=0: ARMED, D=4'b1000 -> ALARM on next edge, pend never 1.
REQ-035 rst_n pulled low between clock edges during ENTRY -> L, pend, cnt, zone go 0 without a clock edge; st=IDLE.
